// File: rtl/serial_digit_adder.sv
// serial_digit_adder
//   Adds two WIDTH-bit operands plus a carry-in, DIGIT bits per clock, using a
//   registered ripple carry. The result is available NDIG = WIDTH/DIGIT cycles
//   after an accepted start, with a one-cycle done pulse.
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   start     in   request, sampled only while idle
//   A, B      in   WIDTH-bit operands, captured on accepted start
//   Cin       in   carry-in, captured on accepted start
//   busy      out  high while a sum is in progress
//   done      out  one-cycle pulse when Sum/Cout/overflow update
//   Sum       out  (A+B+Cin) mod 2^WIDTH
//   Cout      out  unsigned carry out of the MSB
//   overflow  out  signed overflow (carry into MSB xor carry out of MSB)
module serial_digit_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             overflow
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0]    LAST  = CW'(NDIG - 1);
  localparam logic [WIDTH-1:0] DMASK = WIDTH'({DIGIT{1'b1}});

  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_digit_adder: WIDTH must be >= 1 and divisible by DIGIT, 1 <= DIGIT <= WIDTH");
  end

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_last;

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_opA;
  logic [WIDTH-1:0] r_opB;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_done;

  logic [31:0]      w_sh;
  logic [WIDTH-1:0] w_a_sh;
  logic [WIDTH-1:0] w_b_sh;
  logic [DIGIT-1:0] w_a_dig;
  logic [DIGIT-1:0] w_b_dig;
  logic [DIGIT:0]   w_dsum;
  logic             w_cmsb;
  logic [WIDTH-1:0] w_acc_nxt;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == LAST) begin
          w_last      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ------------------------------------------------------- digit adder
  // The current digit is brought down to bit 0 with a shift rather than a
  // variable part-select, so the same code covers DIGIT == WIDTH.
  always_comb begin
    w_sh      = 32'(r_cnt) * 32'(DIGIT);
    w_a_sh    = r_opA >> w_sh;
    w_b_sh    = r_opB >> w_sh;
    w_a_dig   = w_a_sh[DIGIT-1:0];
    w_b_dig   = w_b_sh[DIGIT-1:0];
    w_dsum    = {1'b0, w_a_dig} + {1'b0, w_b_dig} + (DIGIT+1)'(r_carry);
    // Carry into the digit's top bit recovered from the sum bit: a ^ b ^ s.
    w_cmsb    = w_a_dig[DIGIT-1] ^ w_b_dig[DIGIT-1] ^ w_dsum[DIGIT-1];
    w_acc_nxt = (r_acc & ~(DMASK << w_sh)) | (WIDTH'(w_dsum[DIGIT-1:0]) << w_sh);
  end

  // ---------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_opA   <= '0;
      r_opB   <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_opA   <= A;
        r_opB   <= B;
        r_carry <= Cin;
        r_acc   <= '0;
        r_cnt   <= '0;
      end else if (r_state == S_RUN) begin
        r_acc   <= w_acc_nxt;
        r_carry <= w_dsum[DIGIT];
        r_cnt   <= r_cnt + CW'(1);
        if (w_last) begin
          // Final digit: publish the accumulator including this digit.
          r_sum  <= w_acc_nxt;
          r_cout <= w_dsum[DIGIT];
          r_ovf  <= w_cmsb ^ w_dsum[DIGIT];
          r_done <= 1'b1;
          r_cnt  <= '0;
        end
      end
    end
  end

  assign busy     = (r_state == S_RUN);
  assign done     = r_done;
  assign Sum      = r_sum;
  assign Cout     = r_cout;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_digit_adder.sv
// Bench for serial_digit_adder: five instances (WIDTH/DIGIT = 16/1, 16/2,
// 16/4, 16/16, 1/1) share stimulus; each is checked against an arithmetic
// reference for result and latency.
module tb_serial_digit_adder;

  localparam int NI = 5;
  int ndig [NI] = '{16, 8, 4, 1, 1};
  int wid  [NI] = '{16, 16, 16, 16, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, start = 1'b0, Cin = 1'b0;
  logic [15:0] A = '0, B = '0;
  logic [NI-1:0] busy, done, cout, ovf;
  logic [15:0] sum [NI];
  logic        sum_w1;
  assign sum[4] = {15'b0, sum_w1};

  serial_digit_adder #(.WIDTH(16), .DIGIT(1)) u_d1 (.clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Cin(Cin),
    .busy(busy[0]), .done(done[0]), .Sum(sum[0]), .Cout(cout[0]), .overflow(ovf[0]));
  serial_digit_adder #(.WIDTH(16), .DIGIT(2)) u_d2 (.clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Cin(Cin),
    .busy(busy[1]), .done(done[1]), .Sum(sum[1]), .Cout(cout[1]), .overflow(ovf[1]));
  serial_digit_adder #(.WIDTH(16), .DIGIT(4)) u_d4 (.clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Cin(Cin),
    .busy(busy[2]), .done(done[2]), .Sum(sum[2]), .Cout(cout[2]), .overflow(ovf[2]));
  serial_digit_adder #(.WIDTH(16), .DIGIT(16)) u_d16 (.clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Cin(Cin),
    .busy(busy[3]), .done(done[3]), .Sum(sum[3]), .Cout(cout[3]), .overflow(ovf[3]));
  serial_digit_adder #(.WIDTH(1), .DIGIT(1)) u_w1 (.clk(clk), .rst(rst), .start(start), .A(A[0:0]), .B(B[0:0]), .Cin(Cin),
    .busy(busy[4]), .done(done[4]), .Sum(sum_w1), .Cout(cout[4]), .overflow(ovf[4]));

  // Edge counter and per-instance done bookkeeping (value of cyc at the edge
  // that samples done high).
  int cyc = 0;
  int done_cnt [NI] = '{default: 0};
  int done_cyc [NI] = '{default: 0};
  int prev_cyc [NI] = '{default: 0};
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NI; i++)
      if (done[i]) begin
        done_cnt[i] <= done_cnt[i] + 1;
        prev_cyc[i] <= done_cyc[i];
        done_cyc[i] <= cyc;
      end
  end

  int n_cmp = 0, n_bad = 0;
  int base [NI];
  int bcyc [NI];
  bit excl_bad;

  // Reference: {overflow, Cout, Sum} from plain integer addition.
  function automatic logic [17:0] model(input int w, input logic [15:0] a, input logic [15:0] b, input logic c);
    logic [16:0] t;
    logic [1:0]  t1;
    if (w == 1) begin
      t1 = 2'(a[0]) + 2'(b[0]) + 2'(c);
      return {(a[0] == b[0]) && (t1[0] != a[0]), t1[1], 15'b0, t1[0]};
    end
    t = 17'(a) + 17'(b) + 17'(c);
    return {(a[15] == b[15]) && (t[15] != a[15]), t};
  endfunction

  // One-cycle start pulse, then wait (bounded) until every instance completes.
  task automatic launch_wait(input logic [15:0] a, input logic [15:0] b, input logic c,
                             output int s, output bit ok);
    @(negedge clk);
    A = a; B = b; Cin = c; start = 1'b1;
    s = cyc;
    excl_bad = 1'b0;
    for (int i = 0; i < NI; i++) begin base[i] = done_cnt[i]; bcyc[i] = 0; end
    ok = 1'b0;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      start = 1'b0;
      ok = 1'b1;
      for (int i = 0; i < NI; i++) begin
        if (busy[i]) bcyc[i]++;
        if (busy[i] && done[i]) excl_bad = 1'b1;
        if (done_cnt[i] == base[i]) ok = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      n_cmp++;
      if ({busy[i], done[i], ovf[i], cout[i], sum[i]} !== 20'h0) begin
        n_bad++;
        $display("FAIL reset[%0d] got busy=%b done=%b ovf=%b cout=%b sum=%h, want all 0",
                 i, busy[i], done[i], ovf[i], cout[i], sum[i]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [15:0] ta [5] = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h8000};
    logic [15:0] tb [5] = '{16'h4321, 16'h0000, 16'h0001, 16'h0001, 16'h8000};
    logic        tc [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [17:0] te [5] = '{{2'b00, 16'h5555}, {2'b01, 16'h0000}, {2'b01, 16'h0000},
                            {2'b10, 16'h8000}, {2'b11, 16'h0000}};
    int s; bit ok;
    logic [17:0] got;
    for (int k = 0; k < 5; k++) begin
      launch_wait(ta[k], tb[k], tc[k], s, ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL directed%0d timeout waiting for done", k); end
      got = {ovf[2], cout[2], sum[2]};
      n_cmp++;
      if (got !== te[k]) begin
        n_bad++; $display("FAIL directed%0d d4 result got %h want %h", k, got, te[k]);
      end
      n_cmp++;
      if (bcyc[2] != 4) begin
        n_bad++; $display("FAIL directed%0d d4 busy cycles got %0d want 4", k, bcyc[2]);
      end
      n_cmp++;
      if (excl_bad) begin n_bad++; $display("FAIL directed%0d busy&done both high got 1 want 0", k); end
      for (int i = 0; i < NI; i++) begin
        got = model(wid[i], ta[k], tb[k], tc[k]);
        n_cmp++;
        if ({ovf[i], cout[i], sum[i]} !== got) begin
          n_bad++; $display("FAIL directed%0d inst%0d got %h want %h", k, i, {ovf[i], cout[i], sum[i]}, got);
        end
        n_cmp++;
        if (done_cyc[i] - s - 1 != ndig[i]) begin
          n_bad++; $display("FAIL directed%0d inst%0d latency got %0d want %0d", k, i, done_cyc[i] - s - 1, ndig[i]);
        end
      end
    end
  endtask

  task automatic test_start_while_busy();
    int s;
    logic [17:0] exp;
    @(negedge clk);
    A = 16'h1234; B = 16'h4321; Cin = 1'b0; start = 1'b1; s = cyc;
    for (int i = 0; i < NI; i++) base[i] = done_cnt[i];
    @(negedge clk); start = 1'b0;
    @(negedge clk); A = 16'h0001; B = 16'h0001; Cin = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0; A = 16'hFFFF; B = 16'hFFFF;
    repeat (25) @(negedge clk);
    exp = model(16, 16'h1234, 16'h4321, 1'b0);
    // Instances with NDIG > 2 are still running when the second start arrives.
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (done_cnt[i] - base[i] != 1) begin
        n_bad++; $display("FAIL busy_start inst%0d done count got %0d want 1", i, done_cnt[i] - base[i]);
      end
      n_cmp++;
      if ({ovf[i], cout[i], sum[i]} !== exp) begin
        n_bad++; $display("FAIL busy_start inst%0d got %h want %h", i, {ovf[i], cout[i], sum[i]}, exp);
      end
      n_cmp++;
      if (done_cyc[i] - s - 1 != ndig[i]) begin
        n_bad++; $display("FAIL busy_start inst%0d latency got %0d want %0d", i, done_cyc[i] - s - 1, ndig[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int s; bit ok;
    logic [17:0] exp;
    logic [15:0] ra, rb;
    @(negedge clk);
    A = 16'hABCD; B = 16'h1111; Cin = 1'b1; start = 1'b1;
    for (int i = 0; i < NI; i++) base[i] = done_cnt[i];
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < NI; i++) begin
      n_cmp++;
      if ({busy[i], done[i], ovf[i], cout[i], sum[i]} !== 20'h0) begin
        n_bad++; $display("FAIL rst_mid inst%0d got busy=%b done=%b ovf=%b cout=%b sum=%h want all 0",
                          i, busy[i], done[i], ovf[i], cout[i], sum[i]);
      end
    end
    repeat (20) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (done_cnt[i] != base[i]) begin
        n_bad++; $display("FAIL rst_mid inst%0d done pulses got %0d want 0", i, done_cnt[i] - base[i]);
      end
    end
    ra = 16'($urandom); rb = 16'($urandom);
    launch_wait(ra, rb, 1'b1, s, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL rst_mid fresh op timeout"); end
    for (int i = 0; i < NI; i++) begin
      exp = model(wid[i], ra, rb, 1'b1);
      n_cmp++;
      if ({ovf[i], cout[i], sum[i]} !== exp) begin
        n_bad++; $display("FAIL rst_mid fresh inst%0d got %h want %h", i, {ovf[i], cout[i], sum[i]}, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] exp;
    @(negedge clk);
    A = 16'h9A5C; B = 16'h6BB3; Cin = 1'b1; start = 1'b1;
    for (int i = 0; i < NI; i++) base[i] = done_cnt[i];
    repeat (60) @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      exp = model(wid[i], 16'h9A5C, 16'h6BB3, 1'b1);
      n_cmp++;
      if (done_cnt[i] - base[i] < 3) begin
        n_bad++; $display("FAIL b2b inst%0d completions got %0d want >=3", i, done_cnt[i] - base[i]);
      end
      n_cmp++;
      if (done_cyc[i] - prev_cyc[i] != ndig[i] + 1) begin
        n_bad++; $display("FAIL b2b inst%0d period got %0d want %0d", i, done_cyc[i] - prev_cyc[i], ndig[i] + 1);
      end
      n_cmp++;
      if ({ovf[i], cout[i], sum[i]} !== exp) begin
        n_bad++; $display("FAIL b2b inst%0d got %h want %h", i, {ovf[i], cout[i], sum[i]}, exp);
      end
    end
  endtask

  task automatic test_sweep();
    int s; bit ok;
    logic [15:0] a, b;
    logic        c;
    logic [17:0] exp;
    for (int k = 0; k < 28; k++) begin
      if (k < 8) begin
        a = {16{k[2]}}; b = {16{k[1]}}; c = k[0];
      end else begin
        a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
      end
      launch_wait(a, b, c, s, ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL sweep%0d timeout", k); end
      n_cmp++;
      if (excl_bad) begin n_bad++; $display("FAIL sweep%0d busy&done both high got 1 want 0", k); end
      for (int i = 0; i < NI; i++) begin
        exp = model(wid[i], a, b, c);
        n_cmp++;
        if ({ovf[i], cout[i], sum[i]} !== exp) begin
          n_bad++; $display("FAIL sweep%0d inst%0d a=%h b=%h c=%b got %h want %h",
                            k, i, a, b, c, {ovf[i], cout[i], sum[i]}, exp);
        end
        n_cmp++;
        if (done_cyc[i] - s - 1 != ndig[i] || bcyc[i] != ndig[i]) begin
          n_bad++; $display("FAIL sweep%0d inst%0d latency got %0d busy %0d want %0d",
                            k, i, done_cyc[i] - s - 1, bcyc[i], ndig[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
